// File: rtl/btb_pkg.sv
// rtl/btb_pkg.sv - shared types, constants and the mispredict qualify rule for the BTB update path
package btb_pkg;

    localparam int BTB_AMSB     = 31;
    localparam int BTB_IDX_BITS = 11;

    typedef struct packed {
        logic                valid;
        logic [BTB_AMSB:0]   pc;
        logic [BTB_AMSB:0]   tgt;
    } btb_upd_t;

    typedef enum logic {
        ST_SWEEP = 1'b0,
        ST_RUN   = 1'b1
    } btb_state_t;

    // A resolved branch needs a BTB write when the prediction was wrong:
    // taken but missed or pointed elsewhere, or not taken yet present.
    function automatic logic btb_qualify(input logic v, input logic taken,
                                         input logic hit, input logic tgt_ne);
        return v && ((taken && (!hit || tgt_ne)) || (!taken && hit));
    endfunction

endpackage

// File: rtl/btb_upd_fifo.sv
// rtl/btb_upd_fifo.sv - multi-push single-pop update FIFO; BTBUPD_COALESCE_EN adds a youngest-entry overwrite port
module btb_upd_fifo #(
    parameter int W     = 65,
    parameter int DEPTH = 16,
    parameter int NPORT = 3,
    parameter int PW    = $clog2(NPORT + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic [PW-1:0]              push_n,
    input  logic [NPORT-1:0][W-1:0]    push_dat,
    input  logic                       pop,
`ifdef BTBUPD_COALESCE_EN
    input  logic                       ow_en,
    input  logic [W-1:0]               ow_dat,
    output logic [W-1:0]               tail,
`endif
    output logic [W-1:0]               head,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     free
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wp;
    logic [AW:0]  rp;
    logic [AW:0]  cnt;

    // Wrap bit makes wp - rp reach DEPTH exactly when the FIFO is full.
    assign cnt   = wp - rp;
    assign free  = (AW + 1)'(DEPTH) - cnt;
    assign empty = (wp == rp);
    assign head  = mem[rp[AW-1:0]];
`ifdef BTBUPD_COALESCE_EN
    assign tail  = mem[wp[AW-1:0] - AW'(1)];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp <= '0;
            rp <= '0;
        end else if (clr) begin
            wp <= '0;
            rp <= '0;
        end else begin
            wp <= wp + (AW + 1)'(push_n);
            rp <= rp + (AW + 1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NPORT; i++) begin
            if (i < int'(push_n)) begin
                mem[wp[AW-1:0] + AW'(i)] <= push_dat[i];
            end
        end
`ifdef BTBUPD_COALESCE_EN
        if (ow_en) begin
            mem[wp[AW-1:0] - AW'(1)] <= ow_dat;
        end
`endif
    end

endmodule

// File: rtl/btb_update_gen.sv
// rtl/btb_update_gen.sv - filters resolved branches into BTB writes and sweeps the BTB invalid; BTBUPD_COALESCE_EN merges same-pc updates into the youngest FIFO entry
module btb_update_gen
    import btb_pkg::*;
#(
    parameter int AMSB     = BTB_AMSB,
    parameter int NPORT    = 3,
    parameter int DEPTH    = 16,
    parameter int IDX_BITS = BTB_IDX_BITS
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NPORT-1:0]            cm_v,
    input  logic [NPORT*(AMSB+1)-1:0]   cm_pc,
    input  logic [NPORT*(AMSB+1)-1:0]   cm_tgt,
    input  logic [NPORT-1:0]            cm_taken,
    input  logic [NPORT-1:0]            cm_hit,
    input  logic [NPORT*(AMSB+1)-1:0]   cm_ptgt,
    input  logic                        flush_req,
    input  logic                        wr_rdy,
    output logic                        wr,
    output logic [AMSB:0]               wadr,
    output logic [AMSB:0]               wdat,
    output logic                        valid,
    output logic                        busy,
    output logic [15:0]                 drop_cnt
);
    localparam int AW   = $clog2(DEPTH);
    localparam int PW   = $clog2(NPORT + 1);
    localparam int EW   = $bits(btb_upd_t);
    localparam int PADW = AMSB + 1 - IDX_BITS;
    localparam logic [IDX_BITS-1:0] IDX_LAST = '1;

    btb_state_t               state;
    logic [IDX_BITS-1:0]      idx;
    logic [IDX_BITS-1:0]      idx_nxt;
    btb_upd_t                 ent  [NPORT];
    btb_upd_t                 list [NPORT];
    logic [NPORT-1:0]         qual;
    logic [NPORT-1:0]         surv;
    logic                     accept;
    logic                     ld;
    logic                     pop;
    logic                     byp;
    logic                     coal;
    logic                     fifo_empty;
    logic [AW:0]              fifo_free;
    logic [EW-1:0]            head_raw;
    btb_upd_t                 head;
    logic [PW-1:0]            npush;
    logic [PW-1:0]            ndrop;
    logic [NPORT-1:0][EW-1:0] pdat;
    logic [16:0]              drop_sum;
    int                       nsurv;
    int                       navail;
    int                       nroom;
    int                       nfit;
    int                       skip;
`ifdef BTBUPD_COALESCE_EN
    logic [EW-1:0]            tail_raw;
    btb_upd_t                 tail;
    assign tail = tail_raw;
`endif

    assign head     = head_raw;
    assign idx_nxt  = idx + IDX_BITS'(1);
    assign accept   = (state == ST_RUN) && !flush_req;
    assign ld       = !wr || wr_rdy;
    assign pop      = accept && ld && !fifo_empty;
    assign drop_sum = {1'b0, drop_cnt} + 17'(ndrop);

    always_comb begin
        for (int k = 0; k < NPORT; k++) begin
            ent[k].valid = cm_taken[k];
            ent[k].pc    = cm_pc[k*(AMSB+1) +: AMSB+1];
            ent[k].tgt   = cm_tgt[k*(AMSB+1) +: AMSB+1];
            qual[k]      = btb_qualify(cm_v[k], cm_taken[k], cm_hit[k],
                                       cm_ptgt[k*(AMSB+1) +: AMSB+1] != cm_tgt[k*(AMSB+1) +: AMSB+1]);
        end
    end

    // Within one cycle the youngest port owns a pc; older duplicates vanish silently.
    always_comb begin
        surv = qual;
        for (int k = 0; k < NPORT; k++) begin
            for (int j = k + 1; j < NPORT; j++) begin
                if (qual[j] && ent[j].pc == ent[k].pc) begin
                    surv[k] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        nsurv = 0;
        for (int k = 0; k < NPORT; k++) begin
            list[k] = '0;
        end
        for (int k = 0; k < NPORT; k++) begin
            if (accept && surv[k]) begin
                list[nsurv] = ent[k];
                nsurv       = nsurv + 1;
            end
        end
        byp = ld && fifo_empty && (nsurv != 0);
`ifdef BTBUPD_COALESCE_EN
        // Skip the merge when the youngest entry is also the one leaving this cycle.
        coal = !fifo_empty && (nsurv != 0) && (list[0].pc == tail.pc)
               && !(pop && fifo_free == (AW + 1)'(DEPTH - 1));
`else
        coal = 1'b0;
`endif
        skip   = int'(byp) + int'(coal);
        navail = nsurv - skip;
        nroom  = int'(fifo_free) + int'(pop);
        nfit   = (navail < nroom) ? navail : nroom;
        npush  = PW'(nfit);
        ndrop  = PW'(navail - nfit);
        for (int i = 0; i < NPORT; i++) begin
            pdat[i] = (i + skip < NPORT) ? list[i + skip] : '0;
        end
    end

    btb_upd_fifo #(
        .W     (EW),
        .DEPTH (DEPTH),
        .NPORT (NPORT),
        .PW    (PW)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .clr      ((state == ST_RUN) && flush_req),
        .push_n   (npush),
        .push_dat (pdat),
        .pop      (pop),
`ifdef BTBUPD_COALESCE_EN
        .ow_en    (coal),
        .ow_dat   (list[0]),
        .tail     (tail_raw),
`endif
        .head     (head_raw),
        .empty    (fifo_empty),
        .free     (fifo_free)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_SWEEP;
            idx      <= '0;
            wr       <= 1'b0;
            wadr     <= '0;
            wdat     <= '0;
            valid    <= 1'b0;
            busy     <= 1'b1;
            drop_cnt <= '0;
        end else begin
            case (state)
                ST_SWEEP: begin
                    if (!wr) begin
                        wr    <= 1'b1;
                        wadr  <= {{PADW{1'b0}}, idx};
                        wdat  <= '0;
                        valid <= 1'b0;
                    end else if (wr_rdy) begin
                        if (idx == IDX_LAST) begin
                            state <= ST_RUN;
                            busy  <= 1'b0;
                            idx   <= '0;
                            wr    <= 1'b0;
                        end else begin
                            idx  <= idx_nxt;
                            wadr <= {{PADW{1'b0}}, idx_nxt};
                        end
                    end
                end
                ST_RUN: begin
                    if (flush_req) begin
                        state <= ST_SWEEP;
                        busy  <= 1'b1;
                        idx   <= '0;
                        wr    <= 1'b0;
                    end else begin
                        if (pop) begin
                            wr    <= 1'b1;
                            wadr  <= head.pc;
                            wdat  <= head.tgt;
                            valid <= head.valid;
                        end else if (byp) begin
                            wr    <= 1'b1;
                            wadr  <= list[0].pc;
                            wdat  <= list[0].tgt;
                            valid <= list[0].valid;
                        end else if (ld) begin
                            wr <= 1'b0;
                        end
                        if (ndrop != '0) begin
                            drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
                        end
                    end
                end
                default: state <= ST_SWEEP;
            endcase
        end
    end

endmodule

// File: tb/tb_btb_update_gen.sv
// tb/tb_btb_update_gen.sv - randomized bench for btb_update_gen against a queue-based reference model
module tb_btb_update_gen;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  cm_v, cm_taken, cm_hit;
    logic [95:0] cm_pc, cm_tgt, cm_ptgt;
    logic        flush_req, wr_rdy;
    logic        wr, valid, busy;
    logic [31:0] wadr, wdat;
    logic [15:0] drop_cnt;

    always #5 clk = ~clk;

    btb_update_gen dut (
        .clk(clk), .rst(rst), .cm_v(cm_v), .cm_pc(cm_pc), .cm_tgt(cm_tgt),
        .cm_taken(cm_taken), .cm_hit(cm_hit), .cm_ptgt(cm_ptgt),
        .flush_req(flush_req), .wr_rdy(wr_rdy), .wr(wr), .wadr(wadr),
        .wdat(wdat), .valid(valid), .busy(busy), .drop_cnt(drop_cnt)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic        vb;
    } exp_t;

    exp_t q[$];
    int   exp_drop = 0;
    int   n_tests  = 0;
    int   n_fail   = 0;

    task automatic set_port(input int k, input logic v, input logic tk, input logic h,
                            input logic [31:0] p, input logic [31:0] t, input logic [31:0] pt);
        cm_v[k] = v; cm_taken[k] = tk; cm_hit[k] = h;
        cm_pc[k*32 +: 32] = p; cm_tgt[k*32 +: 32] = t; cm_ptgt[k*32 +: 32] = pt;
    endtask

    task automatic clear_ports();
        cm_v = '0; cm_taken = '0; cm_hit = '0;
        cm_pc = '0; cm_tgt = '0; cm_ptgt = '0;
    endtask

    task automatic rand_ports(input int pool);
        for (int k = 0; k < 3; k++) begin
            set_port(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     32'h1000 + 32'($urandom_range(0, pool - 1)) * 4,
                     32'h2000 + 32'($urandom_range(0, 3)) * 4,
                     32'h2000 + 32'($urandom_range(0, 3)) * 4);
        end
    endtask

    function automatic bit mispredicted(input int k);
        logic [31:0] t  = cm_tgt[k*32 +: 32];
        logic [31:0] pt = cm_ptgt[k*32 +: 32];
        if (!cm_v[k]) return 1'b0;
        if (cm_taken[k]) return !cm_hit[k] || (pt != t);
        return cm_hit[k];
    endfunction

    // Check the current outputs against the model, apply this cycle's inputs to it, then advance.
    task automatic step();
        n_tests++;
        if (q.size() == 0) begin
            if (wr !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_wr: got wr=%b want 0 (adr=%h)", wr, wadr);
            end
        end else if ({wr, wadr, wdat, valid} !== {1'b1, q[0].a, q[0].d, q[0].vb}) begin
            n_fail++;
            $display("FAIL write: got wr=%b adr=%h dat=%h v=%b want wr=1 adr=%h dat=%h v=%b",
                     wr, wadr, wdat, valid, q[0].a, q[0].d, q[0].vb);
        end
        n_tests++;
        if (drop_cnt !== 16'(exp_drop)) begin
            n_fail++;
            $display("FAIL drop_cnt: got %0d want %0d", drop_cnt, exp_drop);
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL run_busy: got %b want 0", busy);
        end
        if (flush_req) begin
            q.delete();
        end else begin
            if (q.size() > 0 && wr_rdy) void'(q.pop_front());
            for (int k = 0; k < 3; k++) begin
                bit dup = 1'b0;
                if (!mispredicted(k)) continue;
                for (int j = k + 1; j < 3; j++)
                    if (mispredicted(j) && cm_pc[j*32 +: 32] == cm_pc[k*32 +: 32]) dup = 1'b1;
                if (dup) continue;
                if (q.size() < DEPTH + 1)
                    q.push_back('{cm_pc[k*32 +: 32], cm_tgt[k*32 +: 32], cm_taken[k]});
                else if (exp_drop < 65535)
                    exp_drop++;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic do_sweep(input int n);
        n_tests++;
        if (wr !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL sweep_start: got wr=%b busy=%b want wr=0 busy=1", wr, busy);
        end
        wr_rdy = 1'b1;
        for (int i = 0; i < n; i++) begin
            rand_ports(8);
            flush_req = ($urandom_range(0, 31) == 0);
            @(posedge clk); #1;
            n_tests++;
            if ({wr, wadr, wdat, valid, busy} !== {1'b1, 32'(i), 32'h0, 1'b0, 1'b1}) begin
                n_fail++;
                $display("FAIL sweep_write: got wr=%b adr=%h dat=%h v=%b busy=%b want wr=1 adr=%h dat=0 v=0 busy=1",
                         wr, wadr, wdat, valid, busy, i);
            end
        end
        if (n == 2048) begin
            rand_ports(8);
            @(posedge clk); #1;
            n_tests++;
            if (wr !== 1'b0 || busy !== 1'b0 || drop_cnt !== 16'(exp_drop)) begin
                n_fail++;
                $display("FAIL sweep_end: got wr=%b busy=%b drop=%0d want wr=0 busy=0 drop=%0d",
                         wr, busy, drop_cnt, exp_drop);
            end
        end
        clear_ports();
        flush_req = 1'b0;
    endtask

    task automatic drain();
        clear_ports();
        flush_req = 1'b0;
        wr_rdy    = 1'b1;
        for (int i = 0; i < 64 && q.size() > 0; i++) step();
        step();
    endtask

    task automatic test_reset();
        rst = 1'b0; clear_ports(); flush_req = 1'b0; wr_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({wr, wadr, wdat, valid, busy, drop_cnt} !== {1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 16'h0}) begin
            n_fail++;
            $display("FAIL reset_values: got wr=%b adr=%h dat=%h v=%b busy=%b drop=%0d want 0/0/0/0/1/0",
                     wr, wadr, wdat, valid, busy, drop_cnt);
        end
        q.delete(); exp_drop = 0;
        @(negedge clk) rst = 1'b1;
        do_sweep(2048);
    endtask

    task automatic test_single();
        wr_rdy = 1'b1; clear_ports();
        set_port(0, 1, 1, 0, 32'h100, 32'h200, 32'h0);
        step(); clear_ports(); step(); step();
    endtask

    task automatic test_filter();
        set_port(1, 1, 1, 1, 32'h104, 32'h300, 32'h300);
        set_port(2, 1, 0, 1, 32'h108, 32'h10C, 32'h500);
        step(); clear_ports(); step(); step();
    endtask

    task automatic test_dup();
        set_port(0, 1, 1, 0, 32'h180, 32'h1A0, 32'h0);
        set_port(2, 1, 1, 0, 32'h180, 32'h1C0, 32'h0);
        step(); clear_ports(); step(); step();
    endtask

    task automatic test_overflow();
        wr_rdy = 1'b0;
        for (int c = 0; c < 7; c++) begin
            for (int k = 0; k < 3; k++)
                set_port(k, 1, 1, 0, 32'h400 + 32'(c * 3 + k) * 4, 32'h800 + 32'(c * 3 + k), 32'h0);
            step();
        end
        clear_ports();
        step();
        n_tests++;
        if (drop_cnt !== 16'd4) begin
            n_fail++;
            $display("FAIL overflow_drops: got %0d want 4", drop_cnt);
        end
        drain();
    endtask

    task automatic test_random();
        int pct = 90;
        for (int c = 0; c < 600; c++) begin
            if (c % 100 == 0) pct = (c % 300 == 0) ? 90 : ((c % 300 == 100) ? 50 : 10);
            rand_ports(6);
            wr_rdy = ($urandom_range(0, 99) < pct);
            step();
        end
        drain();
    endtask

    task automatic test_saturate();
        wr_rdy = 1'b0;
        for (int k = 0; k < 3; k++) set_port(k, 1, 1, 0, 32'h7000 + 32'(k) * 4, 32'h9000, 32'h0);
        for (int c = 0; c < 21900; c++) step();
        n_tests++;
        if (drop_cnt !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL drop_saturate: got %h want ffff", drop_cnt);
        end
        drain();
    endtask

    task automatic test_flush();
        wr_rdy = 1'b0; clear_ports();
        for (int c = 0; c < 5; c++) begin
            set_port(0, 1, 1, 0, 32'h5000 + 32'(c) * 4, 32'h6000, 32'h0);
            step();
        end
        for (int k = 0; k < 3; k++) set_port(k, 1, 1, 0, 32'h5800 + 32'(k) * 4, 32'h6100, 32'h0);
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        do_sweep(2048);
        wr_rdy = 1'b1;
        repeat (4) step();
    endtask

    task automatic test_mid_reset();
        #2 rst = 1'b0;
        #2;
        n_tests++;
        if (wr !== 1'b0 || busy !== 1'b1 || drop_cnt !== 16'h0) begin
            n_fail++;
            $display("FAIL async_reset: got wr=%b busy=%b drop=%0d want 0/1/0", wr, busy, drop_cnt);
        end
        q.delete(); exp_drop = 0;
        @(negedge clk) rst = 1'b1;
        do_sweep(300);
        #2 rst = 1'b0;
        #2;
        n_tests++;
        if (wr !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_sweep_reset: got wr=%b busy=%b want 0/1", wr, busy);
        end
        @(negedge clk) rst = 1'b1;
        do_sweep(2048);
        test_single();
    endtask

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_filter();
        test_dup();
        test_overflow();
        test_random();
        test_saturate();
        test_flush();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
